ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage for the MIPS core. It holds the program counter and issues word-aligned requests to a synchronous instruction memory with 1-cycle read latency. Returned words are buffered in a small instruction queue and presented to decode through a valid/ready handshake. A redirect from execute flushes all fetched-but-unconsumed work and restarts fetch at the target.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- IQ_DEPTH, 2, instruction queue entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  fetch address, always word-aligned (equals current pc).
- imem_rdata  in  32  instruction word; valid exactly one cycle after the cycle in which imem_req was high.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  32  target; bits [1:0] ignored (forced to 00).
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  32  queue head instruction.
- instr_pc  out  32  address of instr.
- pc_plus4  out  32  instr_pc + 4, modulo 2^32.

## Operation

- State: pc (32b), started (1b), inflight (1b, plus the address of the in-flight request), queue of IQ_DEPTH {instr, pc} entries with rd/wr pointers and count (0..IQ_DEPTH).
- Reset values: pc=RESET_PC, started=0, inflight=0, count=0, pointers=0. Outputs during reset: imem_req=0, instr_valid=0, imem_addr=RESET_PC, instr/instr_pc/pc_plus4 don't-care (0 recommended).
- started is set at the first rising edge with rst_n high and stays set. It exists so that no request is issued in the reset-release cycle.
- pop = instr_valid & instr_ready.
- imem_req = started & ~redirect_valid & (count + inflight - pop < IQ_DEPTH).
- On a request edge: inflight<=1, captured_pc<=pc, pc<=pc+4 (wraps at 2^32). Otherwise inflight<=0.
- When inflight=1 at an edge with no redirect, push {imem_rdata, captured_pc} into the queue.
- Push and pop at the same edge are both performed. count is unchanged, and the queue never overflows because of the request guard.
- Redirect (redirect_valid=1 at an edge):
  - pc<=redirect_pc & ~3.
  - Queue cleared (count=0, pointers reset).
  - inflight<=0, and the in-flight response is discarded.
  - No request is issued in the redirect cycle.
- Redirect coinciding with pop: the popped instruction counts as consumed by decode; the flush then proceeds as above.
- Redirect coinciding with an arriving response: the response is dropped.
- A redirect while count=IQ_DEPTH behaves identically to any other redirect.
- Outputs instr/instr_pc/pc_plus4 come from the queue head registers, with no combinational path from imem_rdata.

## Timing

- Let E0 be the first edge after rst_n rises.
  - Cycle after E0: imem_req=1, imem_addr=RESET_PC.
  - E1: the request is accepted.
  - E2: the word is pushed.
  - After E2: instr_valid=1 with instr_pc=RESET_PC.
- Fetch-to-decode latency is 2 cycles from request.
- Sustained throughput is 1 instruction/cycle with instr_ready held high (steady state count=1, inflight=1).
- Redirect at edge R: imem_req=1 with imem_addr=target in the cycle after R; instr_valid=0 until after edge R+2; the first valid instr_pc is the target.
- With instr_ready=0: the queue fills to IQ_DEPTH, then imem_req=0 and pc holds.
- instr_valid, instr and instr_pc stay stable while instr_valid=1 and instr_ready=0, absent a redirect.

## Configuration

- IFETCH_PERF_EN defined:
  - Adds output ports perf_fetched (32b) and perf_flushed (32b), both reset to 0.
  - perf_fetched increments on each pop.
  - perf_flushed increments by the number of entries discarded at a redirect: count minus pop, plus the in-flight response if one is present.
  - Both counters wrap at 2^32.
- IFETCH_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan

- Reset release, RESET_PC=0, instr_ready=1, memory returns addr^32'hA5A5_0000 → instr_pc sequence 0,4,8,12 on consecutive cycles from E2; instr matches; pc_plus4 = instr_pc+4.
- Hold instr_ready=0 for 6 cycles → count saturates at 2, imem_req=0, instr_pc stays 0; release instr_ready → delivery resumes with 0,4,8 and no gaps or duplicates.
- Steady stream, redirect_valid=1 with redirect_pc=0x0000_0103 while the queue holds 2 entries → next imem_addr=0x100; first valid instr_pc=0x100 two cycles after the redirect edge; no stale instructions delivered.
- Redirect in the same cycle as a pop of instr_pc=8 → the pop of 8 is counted delivered; the in-flight word for 0xC is dropped; the next instr_pc is the target.
- Fetch near 0xFFFF_FFF8 → instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; pc_plus4 of 0xFFFF_FFFC = 0.
- Assert rst_n=0 mid-stream with the queue full → instr_valid and imem_req drop to 0 immediately (asynchronously); after release, fetch restarts at RESET_PC; with IFETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, 1-cycle imem requests, instruction queue, redirect flush
// Optional IFETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CW = $clog2(IQ_DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic          started_q;
  logic          inflight_q, inflight_d;
  logic [31:0]   cap_pc_q, cap_pc_d;
  logic [31:0]   q_instr_q [IQ_DEPTH];
  logic [31:0]   q_pc_q    [IQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          pop;
  logic          push;
  logic [CW:0]   occupancy;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  // A late response is dropped when a redirect lands on the same edge.
  assign push        = inflight_q & ~redirect_valid;
  assign occupancy   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign imem_req    = started_q & ~redirect_valid & (occupancy < (CW+1)'(IQ_DEPTH));
  assign imem_addr   = pc_q;

  assign instr    = q_instr_q[rd_ptr_q];
  assign instr_pc = q_pc_q[rd_ptr_q];
  assign pc_plus4 = instr_pc + 32'd4;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = 1'b0;
    cap_pc_d   = cap_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~32'd3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) begin
        inflight_d = 1'b1;
        cap_pc_d   = pc_q;
        pc_d       = pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      started_q  <= 1'b0;
      inflight_q <= 1'b0;
      cap_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      started_q  <= 1'b1;
      inflight_q <= inflight_d;
      cap_pc_q   <= cap_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else if (push) begin
      q_instr_q[wr_ptr_q] <= imem_rdata;
      q_pc_q[wr_ptr_q]    <= cap_pc_q;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_flushed_d = perf_flushed_q;
    // The entry popped on a redirect edge was consumed, so it is not a flush.
    if (redirect_valid)
      perf_flushed_d = perf_flushed_q + 32'(count_q) - 32'(pop) + 32'(inflight_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
// Memory model returns addr ^ 32'hA5A5_0000 one cycle after each request.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_0000;

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  task automatic apply_reset(input logic ready);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = ready;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    imem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetched !== 32'h0) begin errors++; $display("FAIL rst_perf_fetched: got %0d want 0", perf_fetched); end
    checks++; if (perf_flushed !== 32'h0) begin errors++; $display("FAIL rst_perf_flushed: got %0d want 0", perf_flushed); end
`endif
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL release_cycle_req: got %b want 0", imem_req); end
  endtask

  task automatic test_stream;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL e0_req: got %b/%h want 1/00000000", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL e0_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL e1_req: got %b/%h want 1/00000004", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL e1_valid: got %b want 0", instr_valid); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(k) * 32'd4;
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %b/%h want 1/%h", k, instr_valid, instr_pc, exp_pc); end
      checks++; if (instr !== (exp_pc ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, exp_pc ^ 32'hA5A5_0000); end
      checks++; if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, pc_plus4, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_stall;
    apply_reset(1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d]: got %b/%h want 1/00000000", i, instr_valid, instr_pc); end
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_req[%0d]: got %b/%h want 0/00000008", i, imem_req, imem_addr); end
    end
    instr_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL resume_req: got %b/%h want 1/00000008", imem_req, imem_addr); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(k) * 32'd4) begin errors++; $display("FAIL resume_pc[%0d]: got %b/%h want 1/%h", k, instr_valid, instr_pc, 32'(k) * 32'd4); end
    end
  endtask

  task automatic test_redirect;
    apply_reset(1'b0);
    repeat (4) @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL redir_full_head: got %b/%h want 1/00000000", instr_valid, instr_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_cycle_req: got %b want 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r0_valid: got %b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_target_req: got %b/%h want 1/00000100", imem_req, imem_addr); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_flushed !== 32'd2) begin errors++; $display("FAIL redir_perf_flushed: got %0d want 2", perf_flushed); end
    checks++; if (perf_fetched !== 32'd0) begin errors++; $display("FAIL redir_perf_fetched: got %0d want 0", perf_fetched); end
`endif
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h104) begin errors++; $display("FAIL redir_r1: got %b/%h want 0/00000104", instr_valid, imem_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc: got %b/%h want 1/00000100", instr_valid, instr_pc); end
    checks++; if (instr !== 32'hA5A5_0100) begin errors++; $display("FAIL redir_first_instr: got %h want a5a50100", instr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin errors++; $display("FAIL redir_second_pc: got %b/%h want 1/00000104", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect_pop;
    apply_reset(1'b1);
    repeat (5) @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin errors++; $display("FAIL rpop_head: got %b/%h want 1/00000008", instr_valid, instr_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush_valid: got %b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rpop_target_req: got %b/%h want 1/00000200", imem_req, imem_addr); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetched !== 32'd3) begin errors++; $display("FAIL rpop_perf_fetched: got %0d want 3", perf_fetched); end
    checks++; if (perf_flushed !== 32'd1) begin errors++; $display("FAIL rpop_perf_flushed: got %0d want 1", perf_flushed); end
`endif
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rpop_r1_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || pc_plus4 !== 32'h204) begin errors++; $display("FAIL rpop_next: got %b/%h/%h want 1/00000200/00000204", instr_valid, instr_pc, pc_plus4); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0: got %h want fffffff8", imem_addr); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1: got %h want fffffffc", imem_addr); end
    @(negedge clk);
    checks++; if (instr_pc !== 32'hFFFF_FFF8 || pc_plus4 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h/%h want fffffff8/fffffffc", instr_pc, pc_plus4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr2: got %h want 00000000", imem_addr); end
    @(negedge clk);
    checks++; if (instr_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h/%h want fffffffc/00000000", instr_pc, pc_plus4); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap_pc2: got %b/%h/%h want 1/00000000/a5a50000", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_async_reset;
    apply_reset(1'b0);
    repeat (4) @(negedge clk);
    instr_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b/%b want 1/1", imem_req, instr_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL arst_drop: got %b/%b want 0/0", imem_req, instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL arst_addr: got %h want 00000000", imem_addr); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetched !== 32'h0 || perf_flushed !== 32'h0) begin errors++; $display("FAIL arst_perf: got %0d/%0d want 0/0", perf_fetched, perf_flushed); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_restart_req: got %b/%h want 1/00000000", imem_req, imem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL arst_restart_pc: got %b/%h want 1/00000000", instr_valid, instr_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
